// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: shared types and constants for the ALU command sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_BEAT_OP1  = 3'd1,
      S_BEAT_OP2  = 3'd2,
      S_BEAT_OPC  = 3'd3,
      S_BEAT_EXEC = 3'd4,
      S_GAP       = 3'd5,
      S_WAIT_DONE = 3'd6,
      S_RESP      = 3'd7
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_NAND = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;

   localparam int ST_DONE  = 0;
   localparam int ST_CARRY = 1;
   localparam int ST_ZERO  = 2;
   localparam int ST_SIGN  = 3;

   localparam int BEAT_COUNT = 4;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer_if: command, ALU and response signals of the sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op1;
   logic [3:0] cmd_op2;
   logic [3:0] cmd_opcode;
   logic [3:0] alu_data;
   logic       alu_process;
   logic       alu_reset;
   logic [3:0] alu_result;
   logic [3:0] alu_status;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic [2:0] rsp_flags;
   logic       rsp_error;
   logic       busy;

   // master is the sequencer; slave is everything around it (host and ALU)
   modport master (
      input  cmd_valid, cmd_op1, cmd_op2, cmd_opcode, alu_result, alu_status, rsp_ready,
      output cmd_ready, alu_data, alu_process, alu_reset, rsp_valid, rsp_result,
             rsp_flags, rsp_error, busy
   );

   modport slave (
      output cmd_valid, cmd_op1, cmd_op2, cmd_opcode, alu_result, alu_status, rsp_ready,
      input  cmd_ready, alu_data, alu_process, alu_reset, rsp_valid, rsp_result,
             rsp_flags, rsp_error, busy
   );
endinterface

`default_nettype wire

// File: rtl/seq_cycle_timer.sv
// ----------------------------------------------------------------------------
// seq_cycle_timer: loadable saturating down-counter with expiry flag. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_cycle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   output logic             expired_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_value_i;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign expired_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer: serialises one command into ALU beats and returns one response. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 8,
   parameter int MAX_OPCODE     = 6
) (
   input  logic                clk,
   input  logic                reset,
   alu_cmd_sequencer_if.master bus
);

   localparam logic [3:0] c_max_opcode   = 4'(MAX_OPCODE);
   localparam logic [7:0] c_gap_load     = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam logic [7:0] c_timeout_load = 8'(TIMEOUT_CYCLES - 1);

   state_t     state_q;
   state_t     next_beat_q;
   logic [3:0] op2_q;
   logic [3:0] opc_q;
   logic [3:0] alu_data_q;
   logic       alu_process_q;
   logic       flush_q;
   logic       rsp_valid_q;
   logic [3:0] rsp_result_q;
   logic [2:0] rsp_flags_q;
   logic       rsp_error_q;

   state_t     w_next_beat;
   state_t     w_beat_sel;
   logic [3:0] w_beat_data;
   logic       w_timer_load;
   logic [7:0] w_timer_value;
   logic       w_timer_expired;

   // Beat states last one cycle, so loading the timer there arms it for the following GAP/WAIT_DONE
   always_comb begin
      w_next_beat = S_BEAT_EXEC;
      if (state_q == S_BEAT_OP1) begin
         w_next_beat = S_BEAT_OP2;
      end else if (state_q == S_BEAT_OP2) begin
         w_next_beat = S_BEAT_OPC;
      end
      w_beat_sel    = (state_q == S_GAP) ? next_beat_q : w_next_beat;
      w_beat_data   = (w_beat_sel == S_BEAT_OP2) ? op2_q : opc_q;
      w_timer_load  = (state_q == S_BEAT_OP1) || (state_q == S_BEAT_OP2) ||
                      (state_q == S_BEAT_OPC) || (state_q == S_BEAT_EXEC);
      w_timer_value = (state_q == S_BEAT_EXEC) ? c_timeout_load : c_gap_load;
   end

   seq_cycle_timer #(
      .WIDTH (8)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .load_i       (w_timer_load),
      .load_value_i (w_timer_value),
      .expired_o    (w_timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         next_beat_q   <= S_BEAT_OP1;
         op2_q         <= '0;
         opc_q         <= '0;
         alu_data_q    <= '0;
         alu_process_q <= 1'b0;
         flush_q       <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_flags_q   <= '0;
         rsp_error_q   <= 1'b0;
      end else begin
         alu_process_q <= 1'b0;
         flush_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op2_q <= bus.cmd_op2;
                  opc_q <= bus.cmd_opcode;
                  if (bus.cmd_opcode > c_max_opcode) begin
                     rsp_valid_q  <= 1'b1;
                     rsp_error_q  <= 1'b1;
                     rsp_result_q <= '0;
                     rsp_flags_q  <= '0;
                     state_q      <= S_RESP;
                  end else begin
                     alu_process_q <= 1'b1;
                     alu_data_q    <= bus.cmd_op1;
                     state_q       <= S_BEAT_OP1;
                  end
               end
            end
            S_BEAT_OP1, S_BEAT_OP2, S_BEAT_OPC: begin
               if (GAP_CYCLES == 0) begin
                  alu_process_q <= 1'b1;
                  alu_data_q    <= w_beat_data;
                  state_q       <= w_next_beat;
               end else begin
                  next_beat_q <= w_next_beat;
                  state_q     <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_timer_expired) begin
                  alu_process_q <= 1'b1;
                  alu_data_q    <= w_beat_data;
                  state_q       <= next_beat_q;
               end
            end
            S_BEAT_EXEC: begin
               state_q <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (bus.alu_status[ST_DONE]) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_error_q  <= 1'b0;
                  rsp_result_q <= bus.alu_result;
                  rsp_flags_q  <= {bus.alu_status[ST_SIGN], bus.alu_status[ST_ZERO],
                                   bus.alu_status[ST_CARRY]};
                  state_q      <= S_RESP;
               end else if (w_timer_expired) begin
                  // ALU lost sync: flush it so the next command starts at its first-operand beat
                  flush_q      <= 1'b1;
                  rsp_valid_q  <= 1'b1;
                  rsp_error_q  <= 1'b1;
                  rsp_result_q <= '0;
                  rsp_flags_q  <= '0;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.alu_data    = alu_data_q;
   assign bus.alu_process = alu_process_q;
   assign bus.alu_reset   = reset | flush_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_flags   = rsp_flags_q;
   assign bus.rsp_error   = rsp_error_q;

endmodule

`default_nettype wire
